// File: rtl/mux_pipe.sv
// mux_pipe: PORTS independent registered read lanes over a shared DEPTH x WIDTH word array.
// Define MUX_PIPE_RANGE_CHECK_EN to register a per-lane out-of-range flag on err_o.
module mux_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int PORTS = 2,
  localparam int SELW = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DEPTH*WIDTH-1:0] data_i,
  input  logic [PORTS*SELW-1:0]  sel_i,
  input  logic [PORTS-1:0]       valid_i,
  output logic [PORTS-1:0]       ready_o,
  output logic [PORTS*WIDTH-1:0] data_o,
  output logic [PORTS-1:0]       valid_o,
  input  logic [PORTS-1:0]       ready_i,
  output logic [PORTS-1:0]       err_o
);

  // One extra bit so DEPTH itself is representable and the compare cannot wrap.
  localparam logic [SELW:0] DEPTH_W = (SELW+1)'(DEPTH);

  logic [PORTS-1:0]       valid_q, valid_d;
  logic [PORTS*WIDTH-1:0] data_q, data_d;
  logic [PORTS-1:0]       accept;
  logic [PORTS-1:0]       in_range;
  logic [WIDTH-1:0]       lane_word [PORTS];

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    logic [SELW-1:0] sel;
    assign sel          = sel_i[p*SELW +: SELW];
    assign in_range[p]  = {1'b0, sel} < DEPTH_W;
    assign lane_word[p] = in_range[p] ? data_i[sel*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int p = 0; p < PORTS; p++) begin
      if (accept[p]) begin
        valid_d[p]                = 1'b1;
        data_d[p*WIDTH +: WIDTH]  = lane_word[p];
      end else if (ready_i[p]) begin
        valid_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef MUX_PIPE_RANGE_CHECK_EN
  logic [PORTS-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    for (int p = 0; p < PORTS; p++) begin
      if (accept[p]) err_d[p] = ~in_range[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised, registered successor to the combinational word selector.
- Provides PORTS independent read lanes over one shared word array (DEPTH words of WIDTH bits), typically a register-file read path.
- Each lane accepts a select under a valid/ready handshake and returns the selected word from a one-deep output register.
- Supports back-pressure and non-power-of-two DEPTH.

Parameters:
- WIDTH, 32: bits per word.
- DEPTH, 32: number of words; legal range is 2 or more.
- PORTS, 2: number of independent read lanes; legal range is 1 or more.
- SELW (localparam), $clog2(DEPTH): select width per lane.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous reset, active low.
- data_i  input  DEPTH*WIDTH  word array; word k at [k*WIDTH +: WIDTH].
- sel_i  input  PORTS*SELW  lane p select at [p*SELW +: SELW].
- valid_i  input  PORTS  lane p request valid.
- ready_o  output  PORTS  lane p can accept a request.
- data_o  output  PORTS*WIDTH  lane p result at [p*WIDTH +: WIDTH].
- valid_o  output  PORTS  lane p result valid.
- ready_i  input  PORTS  lane p downstream accepts the result.
- err_o  output  PORTS  lane p result came from an out-of-range select; qualified by valid_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active low; it is asserted asynchronously and released synchronously by the integrator.
- Reset values: valid_o = 0, data_o = 0, err_o = 0 on every lane. ready_o is combinational and therefore reads 1 during reset.
- Lane independence: lanes are fully independent. There is no arbitration, and several lanes may select the same word in the same cycle.
- Per-lane state: out_valid, out_data, out_err.
- ready_o[p] = !out_valid[p] || ready_i[p]. This is combinational and gives full throughput of one result per cycle per lane.
- Accept: a request is accepted when valid_i[p] && ready_o[p] at a rising edge.
  - On accept: out_data <= selected word, out_err <= range flag, out_valid <= 1.
  - data_i is sampled in the accept cycle only; later changes to data_i do not affect a held result.
- Drain: on ready_i[p] && out_valid[p] with no accept in the same cycle, out_valid <= 0. out_data and out_err hold their values.
- Simultaneous accept and drain: the new result replaces the old one in the same edge, and out_valid stays 1.
- Stall: if valid_o[p] && !ready_i[p], then data_o[p], err_o[p] and valid_o[p] are held stable and ready_o[p] = 0.
- Latency: exactly 1 cycle from accept to valid_o, with no bubbles under continuous valid_i and ready_i.
- Range check: a select with sel >= DEPTH is out of range. This case exists only when DEPTH is not a power of two. The out-of-range result is always data 0.
- Mid-transfer reset: asserting rst_n_i clears valid_o immediately, regardless of clock. Pending results are discarded and not replayed.
- Sizing: no arithmetic beyond the index compare; the compare is performed at SELW+1 bits so it cannot wrap.

Optional Feature:
- Macro: MUX_PIPE_RANGE_CHECK_EN.
- When defined:
  - err_o[p] is registered with the result: 1 when the accepted sel >= DEPTH, else 0.
  - The out-of-range result data is 0.
- When undefined:
  - err_o is tied to 0 and the range-check logic is omitted.
  - Out-of-range selects still return data 0. This is a functional requirement: no X propagation is permitted.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset: hold rst_n_i = 0 with valid_i = 2'b11 -> valid_o = 0, data_o = 0 and err_o = 0; after release, the first accept produces valid_o one cycle later.
- Basic select, defaults: word k = 32'hA000_0000 + k; lane 0 sel = 5, lane 1 sel = 31, both valid, ready_i = 11 -> next cycle data_o lane 0 = 32'hA000_0005, lane 1 = 32'hA000_001F, valid_o = 11.
- Back-pressure: lane 0 sel = 3 accepted; ready_i[0] = 0 for 4 cycles while data_i and sel_i change -> data_o lane 0 holds 32'hA000_0003 and ready_o[0] = 0 throughout; when ready_i[0] = 1, the pending new request is accepted in that same edge.
- Throughput: 16 back-to-back requests sel = 0..15 on lane 1 with ready_i = 1 -> 16 consecutive valid cycles, in order, with no bubbles.
- Out-of-range: DEPTH = 24, SELW = 5, sel = 27 -> data 0; err_o = 1 with the macro defined, 0 without it; sel = 23 -> word 23 with err_o = 0.
- Async reset mid-stall: a result is held with ready_i = 0 and rst_n_i drops between clock edges -> valid_o falls before the next edge; after release, no stale result reappears.
